// File: rtl/tx_word_serializer.sv
// Serializes one DATA_W-bit word per rising edge of tx_start as a start(0)/data/stop(1)
// frame. Every bit is held for CLKS_PER_BIT clocks, and all outputs come from flops.
module tx_word_serializer #(
    parameter int DATA_W       = 32,
    parameter int CLKS_PER_BIT = 16,
    parameter bit MSB_FIRST    = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_start,
    output logic              tx_sdo,
    output logic              tx_en,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_W + 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_cpb
            $error("tx_word_serializer: CLKS_PER_BIT must be >= 2");
        end
        if (DATA_W < 2) begin : g_bad_dw
            $error("tx_word_serializer: DATA_W must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state_q, state_n;
    logic                start_d;
    logic [BAUD_W-1:0]   baud_q, baud_n;
    logic [BIT_W-1:0]    bit_q, bit_n;
    logic [DATA_W-1:0]   sh_q, sh_n;
    logic                sdo_q, sdo_n;
    logic                en_q, en_n;
    logic                done_q, done_n;

    logic go, baud_wrap, last_bit, head_bit;
    logic [DATA_W-1:0] sh_shifted;

    assign go         = tx_start & ~start_d;
    assign baud_wrap  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign last_bit   = (bit_q == BIT_W'(DATA_W - 1));
    assign head_bit   = MSB_FIRST ? sh_q[DATA_W-1] : sh_q[0];
    assign sh_shifted = MSB_FIRST ? {sh_q[DATA_W-2:0], 1'b0} : {1'b0, sh_q[DATA_W-1:1]};

    // start_d resets high so a level held through reset cannot launch a frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            start_d <= 1'b1;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            sdo_q   <= 1'b1;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            start_d <= tx_start;
            baud_q  <= baud_n;
            bit_q   <= bit_n;
            sh_q    <= sh_n;
            sdo_q   <= sdo_n;
            en_q    <= en_n;
            done_q  <= done_n;
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (go) state_n = START;
            START:   if (baud_wrap) state_n = DATA;
            DATA:    if (baud_wrap && last_bit) state_n = STOP;
            STOP:    if (baud_wrap) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Next values for the registered outputs and datapath.
    always_comb begin
        sdo_n  = sdo_q;
        en_n   = en_q;
        done_n = 1'b0;
        bit_n  = bit_q;
        sh_n   = sh_q;
        baud_n = (state_q == IDLE || baud_wrap) ? '0 : baud_q + BAUD_W'(1);
        case (state_q)
            IDLE: begin
                if (go) begin
                    sh_n  = tx_data;
                    sdo_n = 1'b0;
                    en_n  = 1'b1;
                    bit_n = '0;
                end
            end
            START: begin
                if (baud_wrap) begin
                    sdo_n = head_bit;
                    sh_n  = sh_shifted;
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    bit_n = bit_q + BIT_W'(1);
                    if (last_bit) begin
                        sdo_n = 1'b1;
                    end else begin
                        sdo_n = head_bit;
                        sh_n  = sh_shifted;
                    end
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    en_n   = 1'b0;
                    done_n = 1'b1;
                    bit_n  = '0;
                end
            end
            default: ;
        endcase
    end

    assign tx_sdo  = sdo_q;
    assign tx_en   = en_q;
    assign tx_busy = en_q;
    assign tx_done = done_q;

endmodule
